// File: rtl/wbp2axilm_pkg.sv
// wbp2axilm_pkg
// Shared constants and types for the pipelined Wishbone to AXI-lite master
// bridge: AXI response codes, the fixed protection value driven on both
// address channels, and the direction type used to lock the bridge to either
// reads or writes while transactions are in flight.
package wbp2axilm_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  typedef enum logic {
    DIR_RD = 1'b0,
    DIR_WR = 1'b1
  } dir_t;

  // SLVERR and DECERR both have the upper bit set; OKAY/EXOKAY do not.
  function automatic logic respIsError(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/wbp2axilm.sv
// wbp2axilm
// Pipelined Wishbone slave port bridged onto an AXI-lite master. Up to
// 2^LGFIFO-1 transactions may be in flight, all in the same direction, and
// AXI responses are returned to Wishbone in order as ack/err pulses.
//
// Ports
//   i_clk, i_axi_reset_n      clock, asynchronous active-low reset
//   i_wb_cyc/stb/we           Wishbone cycle, strobe, write enable
//   i_wb_addr[AW]             Wishbone word address
//   i_wb_data[DW], i_wb_sel   write data and byte selects
//   o_wb_stall                request not accepted this cycle
//   o_wb_ack, o_wb_err        single-cycle response pulses
//   o_wb_data[DW]             read data, valid with o_wb_ack
//   o_axi_aw*/w*/b*           AXI-lite write address, data, response
//   o_axi_ar*/r*              AXI-lite read address, response
module wbp2axilm
  import wbp2axilm_pkg::*;
#(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 28,
  parameter int LGFIFO           = 3,
  localparam int DW              = C_AXI_DATA_WIDTH,
  localparam int AW              = C_AXI_ADDR_WIDTH - $clog2(C_AXI_DATA_WIDTH/8)
) (
  input  logic                        i_clk,
  input  logic                        i_axi_reset_n,
  // Wishbone slave
  input  logic                        i_wb_cyc,
  input  logic                        i_wb_stb,
  input  logic                        i_wb_we,
  input  logic [AW-1:0]               i_wb_addr,
  input  logic [DW-1:0]               i_wb_data,
  input  logic [DW/8-1:0]             i_wb_sel,
  output logic                        o_wb_stall,
  output logic                        o_wb_ack,
  output logic                        o_wb_err,
  output logic [DW-1:0]               o_wb_data,
  // AXI-lite write address
  output logic                        o_axi_awvalid,
  input  logic                        i_axi_awready,
  output logic [C_AXI_ADDR_WIDTH-1:0] o_axi_awaddr,
  output logic [2:0]                  o_axi_awprot,
  // AXI-lite write data
  output logic                        o_axi_wvalid,
  input  logic                        i_axi_wready,
  output logic [DW-1:0]               o_axi_wdata,
  output logic [DW/8-1:0]             o_axi_wstrb,
  // AXI-lite write response
  input  logic                        i_axi_bvalid,
  output logic                        o_axi_bready,
  input  logic [1:0]                  i_axi_bresp,
  // AXI-lite read address
  output logic                        o_axi_arvalid,
  input  logic                        i_axi_arready,
  output logic [C_AXI_ADDR_WIDTH-1:0] o_axi_araddr,
  output logic [2:0]                  o_axi_arprot,
  // AXI-lite read response
  input  logic                        i_axi_rvalid,
  output logic                        o_axi_rready,
  input  logic [DW-1:0]               i_axi_rdata,
  input  logic [1:0]                  i_axi_rresp
);

  localparam int                ADDR_LSB  = $clog2(DW/8);
  localparam logic [LGFIFO-1:0] NPEND_MAX = '1;

  logic                        awvalid_q, awvalid_d;
  logic                        wvalid_q, wvalid_d;
  logic                        arvalid_q, arvalid_d;
  logic [C_AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [C_AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [DW-1:0]               wdata_q, wdata_d;
  logic [DW/8-1:0]             wstrb_q, wstrb_d;
  logic [DW-1:0]               rdata_q, rdata_d;
  logic [LGFIFO-1:0]           npending_q, npending_d;
  dir_t                        dir_q, dir_d;
  logic                        flushing_q, flushing_d;
  logic                        ack_q, ack_d;
  logic                        err_q, err_d;

  logic                        stall;
  logic                        accept;
  logic                        respDone;
  logic [1:0]                  respCode;
  dir_t                        reqDir;
  logic [C_AXI_ADDR_WIDTH-1:0] reqByteAddr;

  // Request-side decode. Stall is built from registered state plus the AXI
  // readies and the requested direction, so a slot freed by a response at
  // full only opens up on the following cycle via npending_q.
  always_comb begin
    reqDir      = i_wb_we ? DIR_WR : DIR_RD;
    reqByteAddr = {i_wb_addr, {ADDR_LSB{1'b0}}};
    stall       = 1'b0;
    if (awvalid_q && !i_axi_awready)                  stall = 1'b1;
    if (wvalid_q && !i_axi_wready)                    stall = 1'b1;
    if (arvalid_q && !i_axi_arready)                  stall = 1'b1;
    if (npending_q == NPEND_MAX)                      stall = 1'b1;
    if (flushing_q)                                   stall = 1'b1;
    if ((npending_q != '0) && (reqDir != dir_q))      stall = 1'b1;
    accept = i_wb_cyc && i_wb_stb && !stall;
  end

  // Response-side decode. Only one of bvalid/rvalid can legitimately be
  // active since the bridge never mixes directions in flight; responses
  // arriving with nothing outstanding are ignored so the counter can't wrap.
  always_comb begin
    respCode = i_axi_bvalid ? i_axi_bresp : i_axi_rresp;
    respDone = (i_axi_bvalid || i_axi_rvalid) && (npending_q != '0);
  end

  // Next-state logic for the AXI request channels, the outstanding counter,
  // the flush tracker and the Wishbone response registers.
  always_comb begin
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    arvalid_d  = arvalid_q;
    awaddr_d   = awaddr_q;
    araddr_d   = araddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    rdata_d    = rdata_q;
    npending_d = npending_q;
    dir_d      = dir_q;
    flushing_d = flushing_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;

    // Each valid drops on its own ready, so AW and W may complete in either
    // order; stall keeps a new request out until both halves are gone.
    if (i_axi_awready) awvalid_d = 1'b0;
    if (i_axi_wready)  wvalid_d  = 1'b0;
    if (i_axi_arready) arvalid_d = 1'b0;

    if (accept) begin
      dir_d = reqDir;
      if (reqDir == DIR_WR) begin
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
        awaddr_d  = reqByteAddr;
        wdata_d   = i_wb_data;
        wstrb_d   = i_wb_sel;
      end else begin
        arvalid_d = 1'b1;
        araddr_d  = reqByteAddr;
      end
    end

    case ({accept, respDone})
      2'b10:   npending_d = npending_q + LGFIFO'(1);
      2'b01:   npending_d = npending_q - LGFIFO'(1);
      default: npending_d = npending_q;
    endcase

    if (i_axi_rvalid) rdata_d = i_axi_rdata;

    // Responses that belong to an abandoned or failed burst are swallowed
    // until the count drains; the first error itself is still reported.
    if (respDone && !flushing_q && i_wb_cyc) begin
      ack_d = !respIsError(respCode);
      err_d =  respIsError(respCode);
    end

    if ((respDone && respIsError(respCode)) || (!i_wb_cyc && (npending_q != '0)))
      flushing_d = 1'b1;
    if (npending_d == '0)
      flushing_d = 1'b0;
  end

  // State register. The asynchronous reset drops every valid immediately and
  // forgets anything in flight.
  always_ff @(posedge i_clk or negedge i_axi_reset_n) begin
    if (!i_axi_reset_n) begin
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      awaddr_q   <= '0;
      araddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      npending_q <= '0;
      dir_q      <= DIR_RD;
      flushing_q <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      arvalid_q  <= arvalid_d;
      awaddr_q   <= awaddr_d;
      araddr_q   <= araddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rdata_q    <= rdata_d;
      npending_q <= npending_d;
      dir_q      <= dir_d;
      flushing_q <= flushing_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  // Output mapping. Ack/err are additionally masked by cyc so a master that
  // has just dropped its cycle never sees a stray pulse.
  always_comb begin
    o_wb_stall    = stall;
    o_wb_ack      = ack_q && i_wb_cyc;
    o_wb_err      = err_q && i_wb_cyc;
    o_wb_data     = rdata_q;
    o_axi_awvalid = awvalid_q;
    o_axi_awaddr  = awaddr_q;
    o_axi_awprot  = PROT_DEFAULT;
    o_axi_wvalid  = wvalid_q;
    o_axi_wdata   = wdata_q;
    o_axi_wstrb   = wstrb_q;
    o_axi_bready  = 1'b1;
    o_axi_arvalid = arvalid_q;
    o_axi_araddr  = araddr_q;
    o_axi_arprot  = PROT_DEFAULT;
    o_axi_rready  = 1'b1;
  end

endmodule
